hex_msg_scheduler: RTL

HEX_MSG_SCHEDULER -- requirements
Module: hex_msg_scheduler

---
 rtl/hex_msg_pkg.sv | 29 ++
 rtl/hex_tick_gen.sv | 33 +++
 rtl/hex_msg_scheduler.sv | 125 ++++++++++++
 3 files changed

// File: rtl/hex_msg_pkg.sv
// Shared message ids, message lengths and window size for the HEX scroller.
package hex_msg_pkg;

    typedef enum logic [1:0] {
        LOL   = 2'd0,
        LEVEL = 2'd1,
        DEATH = 2'd2
    } msg_id_t;

    localparam int unsigned WINDOW = 4;
    localparam int unsigned MSG_LEN [3] = '{6, 5, 5};

    // Largest leftmost-character index; messages that fit the window never scroll.
    function automatic logic [4:0] max_offset(input msg_id_t id);
        int unsigned len;
        len = (id == LOL) ? MSG_LEN[0] : ((id == LEVEL) ? MSG_LEN[1] : MSG_LEN[2]);
        return (len > WINDOW) ? 5'(len - WINDOW) : 5'd0;
    endfunction

    function automatic msg_id_t highest(input logic [2:0] pend);
        if (pend[2]) begin
            return DEATH;
        end else if (pend[1]) begin
            return LEVEL;
        end
        return LOL;
    endfunction

endpackage

// File: rtl/hex_tick_gen.sv
// Scroll prescaler: one-cycle step strobe every TICK_MAX cycles, held at zero while cleared.
module hex_tick_gen #(
    parameter int unsigned TICK_MAX = 12_500_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic step
);

    localparam int unsigned CW = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_MAX - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign step = !clear && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || step) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hex_msg_scheduler.sv
// Priority scheduler for scrolling HEX messages (DEATH > LEVEL > LOL).
// Optional abort-on-higher-priority behaviour is enabled with macro HEXMSG_PREEMPT_EN.
module hex_msg_scheduler
    import hex_msg_pkg::*;
#(
    parameter int unsigned TICK_MAX = 12_500_000,
    parameter int unsigned PASSES   = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] req,
    output logic [2:0] grant,
    output logic [2:0] done,
    output logic [1:0] msg_sel,
    output logic [4:0] offset,
    output logic       active
);

    typedef enum logic {StIdle, StShow} state_t;

    localparam logic [3:0] LAST_PASS = 4'(PASSES - 1);

    state_t      state_q, state_d;
    logic [2:0]  pending_q, pending_d;
    logic [2:0]  grant_q, grant_d;
    msg_id_t     sel_q, sel_d;
    logic [4:0]  offset_q, offset_d;
    logic [3:0]  pass_q, pass_d;
    logic        step;
    logic        last_step;
    logic        preempt;

    hex_tick_gen #(
        .TICK_MAX (TICK_MAX)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state_q != StShow),
        .step    (step)
    );

    always_comb begin
        preempt = 1'b0;
`ifdef HEXMSG_PREEMPT_EN
        unique case (sel_q)
            LOL:     preempt = |pending_q[2:1];
            LEVEL:   preempt = pending_q[2];
            default: preempt = 1'b0;
        endcase
`endif
    end

    assign last_step = step && (offset_q >= max_offset(sel_q)) && (pass_q == LAST_PASS);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        sel_d    = sel_q;
        offset_d = offset_q;
        pass_d   = pass_q;
        done     = 3'b000;

        unique case (state_q)
            StIdle: begin
                if (|pending_q) begin
                    state_d  = StShow;
                    sel_d    = highest(pending_q);
                    grant_d  = 3'b001 << sel_d;
                    offset_d = 5'd0;
                    pass_d   = 4'd0;
                end
            end
            StShow: begin
                if (last_step) begin
                    done     = grant_q;
                    state_d  = StIdle;
                    grant_d  = 3'b000;
                    offset_d = 5'd0;
                    pass_d   = 4'd0;
                end else if (preempt) begin
                    // Aborted source keeps its pending bit and is re-shown from the start.
                    state_d  = StIdle;
                    grant_d  = 3'b000;
                    offset_d = 5'd0;
                    pass_d   = 4'd0;
                end else if (step) begin
                    if (offset_q < max_offset(sel_q)) begin
                        offset_d = offset_q + 5'd1;
                    end else begin
                        offset_d = 5'd0;
                        pass_d   = pass_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A request in the completion cycle wins over the clear.
        pending_d = (pending_q & ~done) | req;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            pending_q <= 3'b000;
            grant_q   <= 3'b000;
            sel_q     <= LOL;
            offset_q  <= 5'd0;
            pass_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            offset_q  <= offset_d;
            pass_q    <= pass_d;
        end
    end

    assign grant   = grant_q;
    assign msg_sel = sel_q;
    assign offset  = offset_q;
    assign active  = (state_q == StShow);

endmodule
